// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide scalar types.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
endpackage

// File: rtl/mem_req_ctrl_pkg.sv
// Types shared by the memory-stage request controller and its interface users.
package mem_req_ctrl_pkg;
    import cpu_types_pkg::*;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } mem_ctrl_state_t;

    typedef struct packed {
        word_t addr;
        word_t data;
        logic  ren;
        logic  wen;
        logic  halt;
    } mem_req_t;

    // The cache is word addressed; byte offset bits never reach it.
    function automatic word_t align_word(input word_t a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/mem_req_ctrl_if.sv
// EX/MEM-side inputs, dcache request bus and pipeline control for mem_req_ctrl.
interface mem_req_ctrl_if #(
    parameter int CNT_W = 16
);
    import cpu_types_pkg::*;

    logic             dREN_EX_MEM;
    logic             dWEN_EX_MEM;
    word_t            result_EX_MEM;
    word_t            dmemstore_EX_MEM;
    logic             halt_EX_MEM;
    logic             dhit;
    logic             dmemREN;
    logic             dmemWEN;
    word_t            dmemaddr;
    word_t            dmemstore;
    logic             mem_stall;
    logic             enable_MEM_WB;
    logic             flush_MEM_WB;
    logic             halt_out;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        input  dREN_EX_MEM, dWEN_EX_MEM, result_EX_MEM, dmemstore_EX_MEM,
               halt_EX_MEM, dhit,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
               enable_MEM_WB, flush_MEM_WB, halt_out, mem_timeout, stall_cycles
    );

    modport slave (
        output dREN_EX_MEM, dWEN_EX_MEM, result_EX_MEM, dmemstore_EX_MEM,
               halt_EX_MEM, dhit,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
               enable_MEM_WB, flush_MEM_WB, halt_out, mem_timeout, stall_cycles
    );
endinterface

// File: rtl/mem_req_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority over increment).
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] cnt_r;

    // Count register: holds at all-ones instead of wrapping.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign count = cnt_r;
endmodule

// File: rtl/mem_req_ctrl.sv
// Memory-stage request initiator: drives dcache requests, stalls the pipeline on
// misses, steers MEM/WB enable/flush and retires halt.
module mem_req_ctrl
    import cpu_types_pkg::*;
    import mem_req_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 16
) (
    input  logic          CLK,
    input  logic          RST,
    mem_req_ctrl_if.master bus
);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MAX_WAIT - 1);

    mem_ctrl_state_t  state_r;
    mem_ctrl_state_t  next_state_s;
    mem_req_t         req_r;
    logic             timeout_r;
    logic             access_s;
    logic             ren_s;
    logic             wen_s;
    word_t            addr_s;
    word_t            store_s;
    logic             stall_s;
    logic             enable_s;
    logic             flush_s;
    logic             latch_s;
    logic             wait_inc_s;
    logic             wait_clr_s;
    logic             stall_out_s;
    logic [CNT_W-1:0] wait_cnt_s;
    logic [CNT_W-1:0] stall_cnt_s;

    assign access_s = bus.dREN_EX_MEM | bus.dWEN_EX_MEM;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and request/pipeline-control decode.
    always_comb begin
        next_state_s = state_r;
        ren_s        = 1'b0;
        wen_s        = 1'b0;
        addr_s       = 32'h0000_0000;
        store_s      = 32'h0000_0000;
        stall_s      = 1'b0;
        enable_s     = 1'b0;
        flush_s      = 1'b0;
        latch_s      = 1'b0;
        wait_inc_s   = 1'b0;
        wait_clr_s   = 1'b0;
        case (state_r)
            IDLE: begin
                // Store wins when both strobes are set.
                wen_s   = bus.dWEN_EX_MEM;
                ren_s   = bus.dREN_EX_MEM & ~bus.dWEN_EX_MEM;
                addr_s  = align_word(bus.result_EX_MEM);
                store_s = bus.dmemstore_EX_MEM;
                if (access_s && !bus.dhit) begin
                    stall_s      = 1'b1;
                    flush_s      = 1'b1;
                    latch_s      = 1'b1;
                    next_state_s = WAIT;
                end else if (bus.halt_EX_MEM) begin
                    enable_s     = 1'b1;
                    next_state_s = HALT;
                end else begin
                    enable_s     = 1'b1;
                    next_state_s = IDLE;
                end
            end
            WAIT: begin
                ren_s   = req_r.ren;
                wen_s   = req_r.wen;
                addr_s  = req_r.addr;
                store_s = req_r.data;
                if (bus.dhit) begin
                    enable_s     = 1'b1;
                    wait_clr_s   = 1'b1;
                    next_state_s = req_r.halt ? HALT : IDLE;
                end else begin
                    stall_s      = 1'b1;
                    flush_s      = 1'b1;
                    wait_inc_s   = 1'b1;
                    next_state_s = WAIT;
                end
            end
            HALT: begin
                stall_s      = 1'b1;
                next_state_s = HALT;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Miss latch: the request is frozen here so EX/MEM may change underneath.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_r <= {$bits(mem_req_t){1'b0}};
        end else if (latch_s) begin
            req_r <= '{addr: align_word(bus.result_EX_MEM),
                       data: bus.dmemstore_EX_MEM,
                       ren:  bus.dREN_EX_MEM & ~bus.dWEN_EX_MEM,
                       wen:  bus.dWEN_EX_MEM,
                       halt: bus.halt_EX_MEM};
        end else begin
            req_r <= req_r;
        end
    end

    // Sticky watchdog: sets on the wait cycle that brings the count to MAX_WAIT.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            timeout_r <= 1'b0;
        end else if (wait_inc_s && (wait_cnt_s >= TMO_LAST)) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (wait_inc_s),
        .clr   (wait_clr_s),
        .count (wait_cnt_s)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (stall_out_s),
        .clr   (1'b0),
        .count (stall_cnt_s)
    );

    // IDLE outputs are combinational from EX/MEM, so RST must mask them directly.
    assign stall_out_s       = stall_s & ~RST;
    assign bus.dmemREN       = ren_s & ~RST;
    assign bus.dmemWEN       = wen_s & ~RST;
    assign bus.dmemaddr      = RST ? 32'h0000_0000 : addr_s;
    assign bus.dmemstore     = RST ? 32'h0000_0000 : store_s;
    assign bus.mem_stall     = stall_out_s;
    assign bus.enable_MEM_WB = enable_s & ~RST;
    assign bus.flush_MEM_WB  = flush_s & ~RST;
    assign bus.halt_out      = (state_r == HALT);
    assign bus.mem_timeout   = timeout_r;
    assign bus.stall_cycles  = stall_cnt_s;
endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl: transaction-level reference model feeds a
// queue of expected outputs that a negedge monitor compares against the DUT.
module tb_mem_req_ctrl;
    import cpu_types_pkg::*;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 4;
    localparam int SAT      = (1 << CNT_W) - 1;

    typedef struct {
        bit    ren, wen, chk_addr, stall, en, flush, halt, tmo;
        word_t addr, data;
        int    scnt;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    mem_req_ctrl_if #(.CNT_W(CNT_W)) bus();

    mem_req_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: "is a miss outstanding", "is the CPU halted", plus counts.
    bit    m_busy, m_halted, m_tmo, m_wr, m_halt_l;
    word_t m_addr, m_data;
    int    m_wcnt, m_scnt;
    bit    i_ren, i_wen, i_halt, i_dhit;
    word_t i_addr, i_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        bit   acc;
        e = '{default: 0};
        e.scnt = m_scnt;
        e.tmo  = m_tmo;
        e.halt = m_halted;
        if (m_halted) begin
            e.stall = 1;
        end else if (m_busy) begin
            e.wen = m_wr;  e.ren = !m_wr;
            e.addr = m_addr; e.data = m_data; e.chk_addr = 1;
            e.en = i_dhit; e.stall = !i_dhit; e.flush = !i_dhit;
        end else begin
            acc = i_ren | i_wen;
            e.wen = i_wen; e.ren = i_ren && !i_wen;
            e.addr = i_addr & 32'hFFFF_FFFC; e.data = i_data; e.chk_addr = acc;
            if (acc && !i_dhit) begin
                e.stall = 1; e.flush = 1;
            end else begin
                e.en = 1;
            end
        end
        return e;
    endfunction

    task automatic model_step();
        exp_t e;
        e = model_out();
        if (e.stall && m_scnt < SAT) m_scnt++;
        if (m_halted) begin
            // terminal
        end else if (m_busy) begin
            if (i_dhit) begin
                m_busy = 0; m_halted = m_halt_l; m_wcnt = 0;
            end else begin
                m_wcnt++;
                if (m_wcnt >= MAX_WAIT) m_tmo = 1;
            end
        end else if ((i_ren || i_wen) && !i_dhit) begin
            m_busy = 1; m_wr = i_wen; m_addr = i_addr & 32'hFFFF_FFFC;
            m_data = i_data; m_halt_l = i_halt;
        end else if (i_halt) begin
            m_halted = 1;
        end
    endtask

    task automatic drive(input bit ren, input bit wen, input word_t addr, input word_t data,
                         input bit halt, input bit dhit);
        @(posedge CLK);
        #1;
        model_step();
        i_ren = ren; i_wen = wen; i_addr = addr; i_data = data; i_halt = halt; i_dhit = dhit;
        bus.dREN_EX_MEM      = ren;
        bus.dWEN_EX_MEM      = wen;
        bus.result_EX_MEM    = addr;
        bus.dmemstore_EX_MEM = data;
        bus.halt_EX_MEM      = halt;
        bus.dhit             = dhit;
        exp_q.push_back(model_out());
    endtask

    task automatic drive_rand(input int halt_pct, input int hit_pct);
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
              $urandom_range(0, 99) < halt_pct, $urandom_range(0, 99) < hit_pct);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #1 RST = 1'b1;
        #1;
        chk("rst_dmemREN",   32'(bus.dmemREN), 32'd0);
        chk("rst_dmemWEN",   32'(bus.dmemWEN), 32'd0);
        chk("rst_dmemaddr",  bus.dmemaddr, 32'd0);
        chk("rst_dmemstore", bus.dmemstore, 32'd0);
        chk("rst_stall",     32'(bus.mem_stall), 32'd0);
        chk("rst_enable",    32'(bus.enable_MEM_WB), 32'd0);
        chk("rst_flush",     32'(bus.flush_MEM_WB), 32'd0);
        chk("rst_halt_out",  32'(bus.halt_out), 32'd0);
        chk("rst_timeout",   32'(bus.mem_timeout), 32'd0);
        chk("rst_stall_cyc", 32'(bus.stall_cycles), 32'd0);
        bus.dREN_EX_MEM = 1'b0; bus.dWEN_EX_MEM = 1'b0; bus.halt_EX_MEM = 1'b0;
        bus.dhit = 1'b0; bus.result_EX_MEM = 32'd0; bus.dmemstore_EX_MEM = 32'd0;
        @(posedge CLK);
        #1 RST = 1'b0;
        m_busy = 0; m_halted = 0; m_tmo = 0; m_wr = 0; m_halt_l = 0;
        m_addr = 0; m_data = 0; m_wcnt = 0; m_scnt = 0;
        i_ren = 0; i_wen = 0; i_halt = 0; i_dhit = 0; i_addr = 0; i_data = 0;
    endtask

    // Monitor: one expected snapshot per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("dmemREN",      32'(bus.dmemREN), 32'(e.ren));
                chk("dmemWEN",      32'(bus.dmemWEN), 32'(e.wen));
                chk("mem_stall",    32'(bus.mem_stall), 32'(e.stall));
                chk("enable_MEM_WB", 32'(bus.enable_MEM_WB), 32'(e.en));
                chk("flush_MEM_WB", 32'(bus.flush_MEM_WB), 32'(e.flush));
                chk("en_flush_excl", 32'(bus.enable_MEM_WB & bus.flush_MEM_WB), 32'd0);
                chk("halt_out",     32'(bus.halt_out), 32'(e.halt));
                chk("mem_timeout",  32'(bus.mem_timeout), 32'(e.tmo));
                chk("stall_cycles", 32'(bus.stall_cycles), 32'(e.scnt));
                if (e.chk_addr) begin
                    chk("dmemaddr",  bus.dmemaddr, e.addr);
                    chk("dmemstore", bus.dmemstore, e.data);
                end
            end
        end
    end

    initial begin
        bus.dREN_EX_MEM = 1'b0; bus.dWEN_EX_MEM = 1'b0; bus.halt_EX_MEM = 1'b0;
        bus.dhit = 1'b0; bus.result_EX_MEM = 32'd0; bus.dmemstore_EX_MEM = 32'd0;
        do_reset();

        // Single-cycle load hits.
        repeat (3) drive(1, 0, 32'h0000_0104, 32'h0, 0, 1);
        // Store miss, 3 cycles of latency, EX/MEM inputs changing underneath.
        drive(0, 1, 32'h0000_0200, 32'hDEAD_BEEF, 0, 0);
        drive(1, 0, 32'h0000_0ABC, 32'h1234_5678, 0, 0);
        drive(0, 0, 32'h0000_0F00, 32'h0BAD_F00D, 1, 0);
        drive(1, 1, 32'h0000_0444, 32'h5555_AAAA, 0, 1);
        drive(0, 0, 32'h0, 32'h0, 0, 0);
        // Both strobes plus misaligned address.
        drive(1, 1, 32'h0000_0203, 32'hCAFE_0001, 0, 1);
        // Watchdog: six withheld cycles, then the hit.
        drive(1, 0, 32'h0000_0300, 32'h0, 0, 0);
        repeat (6) drive_rand(0, 0);
        drive(0, 0, 32'h0, 32'h0, 0, 1);
        repeat (2) drive(0, 0, 32'h0, 32'h0, 0, 0);
        // Halt latched behind a pending load.
        drive(1, 0, 32'h0000_0800, 32'h0, 1, 0);
        drive(0, 0, 32'h0, 32'h0, 0, 0);
        drive(0, 0, 32'h0, 32'h0, 0, 1);
        repeat (4) drive_rand(0, 50);
        do_reset();
        // Halt with no access.
        drive(0, 0, 32'h0, 32'h0, 1, 0);
        repeat (4) drive_rand(0, 50);
        do_reset();
        // Reset in the middle of a wait, then a clean hit.
        drive(0, 1, 32'h0000_0600, 32'h1111_2222, 0, 0);
        drive(0, 0, 32'h0, 32'h0, 0, 0);
        do_reset();
        drive(1, 0, 32'h0000_0104, 32'h0, 0, 1);

        // Random traffic without halt (reaches stall counter saturation).
        repeat (250) drive_rand(0, 35);
        do_reset();
        repeat (250) drive_rand(3, 45);
        do_reset();
        repeat (150) drive_rand(2, 20);

        @(negedge CLK);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Memory-stage request initiator for the 5-stage pipeline. Sits between the EX/MEM register outputs and the datapath-to-dcache interface.
- Issues dmemREN/dmemWEN, holds the request stable until dhit, and stalls upstream stages while waiting.
- Drives enable_MEM_WB/flush_MEM_WB into the MEM/WB register, so that register captures dmemload exactly once per access and receives bubbles during waits.
- Handles halt retirement.

Parameters:
- MAX_WAIT, 255: wait cycles on one access before the sticky mem_timeout flag sets.
- CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- CLK  in  1  system clock; all state on posedge
- RST  in  1  asynchronous reset, active-high
- dREN_EX_MEM  in  1  load in MEM stage
- dWEN_EX_MEM  in  1  store in MEM stage
- result_EX_MEM  in  32  ALU result = effective address
- dmemstore_EX_MEM  in  32  store data
- halt_EX_MEM  in  1  halt instruction in MEM stage
- dhit  in  1  cache completed current request this cycle
- dmemREN  out  1  read request to cache
- dmemWEN  out  1  write request to cache
- dmemaddr  out  32  request address, bits [1:0] forced 2'b00
- dmemstore  out  32  request write data
- mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- enable_MEM_WB  out  1  MEM/WB load enable
- flush_MEM_WB  out  1  MEM/WB bubble insert
- halt_out  out  1  CPU halted, sticky
- mem_timeout  out  1  sticky watchdog flag
- stall_cycles  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (asynchronous, immediate, any state):
  - State = IDLE; latches cleared.
  - dmemREN = dmemWEN = 0, dmemaddr = dmemstore = 0.
  - mem_stall = 0, enable_MEM_WB = 0, flush_MEM_WB = 0.
  - halt_out = 0, mem_timeout = 0, stall_cycles = 0.
  - Reset during WAIT drops the request in the same instant.
- Access = dREN_EX_MEM | dWEN_EX_MEM. If both are set, WEN wins and REN is suppressed.
- IDLE:
  - Requests, dmemaddr and dmemstore are combinational from the EX/MEM inputs, giving zero added latency.
  - No access, no halt: enable = 1, flush = 0, stall = 0.
  - Access with dhit the same cycle: enable = 1, stall = 0, stay IDLE. Single-cycle hit.
  - Access without dhit: latch addr, data, kind and halt_EX_MEM; go to WAIT. This cycle: stall = 1, enable = 0, flush = 1.
  - halt_EX_MEM with no access: enable = 1 (halt propagates into MEM/WB); go to HALT next cycle.
  - dhit with no access: ignored.
- WAIT:
  - Requests, dmemaddr and dmemstore come from the latches and are held stable every cycle; EX/MEM input changes are ignored.
  - Without dhit: stall = 1, enable = 0, flush = 1. The wait counter increments; when it equals MAX_WAIT, mem_timeout sets (sticky). The request is not abandoned.
  - On dhit: enable = 1, flush = 0, stall = 0. Next state is HALT if the latched halt is set, else IDLE. The wait counter clears.
- HALT:
  - Requests = 0, stall = 1, enable = 0, flush = 0, halt_out = 1.
  - Terminal until RST.
- stall_cycles: +1 on every posedge where mem_stall = 1; saturates at all-ones; never wraps.
- The FSM never asserts enable_MEM_WB and flush_MEM_WB together.

Decomposition:
- Shared package: mem_ctrl_state_t enum {IDLE, WAIT, HALT}; typedef mem_req_t (addr, data, ren, wen, halt) for the latch.
- word_t comes from cpu_types_pkg.
- One sub-module, sat_counter (CNT_W wide, inc, clr), instantiated for stall_cycles and for the wait counter.

Test Plan:
- Single-cycle hit: load, addr 0x0000_0104, dhit tied high -> dmemREN = 1, dmemaddr = 0x104, enable_MEM_WB = 1, mem_stall = 0, stall_cycles stays 0.
- Miss with 3-cycle latency: store 0xDEADBEEF to 0x200 -> WAIT for 3 cycles with stall = 1, flush = 1, enable = 0; dmemaddr/dmemstore held while EX/MEM inputs change; on dhit enable = 1; stall_cycles = 3.
- Both REN and WEN asserted -> only dmemWEN = 1. Misaligned addr 0x203 -> dmemaddr = 0x200.
- Halt: halt_EX_MEM with no access -> one enable pulse, then halt_out = 1 and stall = 1 forever. Halt latched with a pending load -> HALT entered only after dhit.
- Watchdog: MAX_WAIT = 4, dhit withheld for 6 cycles -> mem_timeout rises after 4 wait cycles and stays set after dhit.
- Reset asserted mid-WAIT -> requests and stall drop immediately; state IDLE; counters 0. Next access behaves as in the single-cycle-hit scenario.
